// File: rtl/sync_fifo_flags_if.sv
// Handshake and status bundle for sync_fifo_flags; master drives requests, slave is the FIFO.
interface sync_fifo_flags_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
);
   logic                  w_en;
   logic [DATA_WIDTH-1:0] data_in;
   logic                  r_en;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  full;
   logic                  empty;
   logic                  almost_full;
   logic                  almost_empty;
   logic [ADDR_WIDTH:0]   af_thresh;
   logic [ADDR_WIDTH:0]   ae_thresh;
   logic [ADDR_WIDTH:0]   count;
   logic                  overflow;
   logic                  underflow;
   logic                  clr_err;

   modport master (
      output w_en, data_in, r_en, af_thresh, ae_thresh, clr_err,
      input  data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
   );

   modport slave (
      input  w_en, data_in, r_en, af_thresh, ae_thresh, clr_err,
      output data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
   );
endinterface

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy counter, programmable almost-full/empty thresholds and sticky errors.
// FWFT=0 registers read data one cycle after the pop; FWFT=1 shows the head word combinationally.
module sync_fifo_flags #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,
   parameter int ADDR_WIDTH = 4,
   parameter bit FWFT       = 1'b0
) (
   input logic              clk,
   input logic              rst,
   sync_fifo_flags_if.slave bus
);
   localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] ONE_C   = (ADDR_WIDTH+1)'(1);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic                  ovf_q, ovf_d;
   logic                  udf_q, udf_d;
   logic                  full, empty, wr_acc, rd_acc;
   logic [DATA_WIDTH-1:0] head;
   logic                  ptr_full, ptr_empty;

   // Flags come from the counter so each side's acceptance never depends on the other side.
   assign full   = (count_q == DEPTH_C);
   assign empty  = (count_q == '0);
   assign wr_acc = bus.w_en & ~full;
   assign rd_acc = bus.r_en & ~empty;
   assign head   = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];

   assign bus.full         = full;
   assign bus.empty        = empty;
   assign bus.almost_full  = (count_q >= bus.af_thresh);
   assign bus.almost_empty = (count_q <= bus.ae_thresh);
   assign bus.count        = count_q;
   assign bus.overflow     = ovf_q;
   assign bus.underflow    = udf_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      udf_d    = udf_q;
      if (wr_acc) wr_ptr_d = wr_ptr_q + ONE_C;
      if (rd_acc) rd_ptr_d = rd_ptr_q + ONE_C;
      case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + ONE_C;
         2'b01:   count_d = count_q - ONE_C;
         default: count_d = count_q;
      endcase
      // A fresh error beats a same-cycle clear.
      if (bus.clr_err) begin
         ovf_d = 1'b0;
         udf_d = 1'b0;
      end
      if (bus.w_en && full)  ovf_d = 1'b1;
      if (bus.r_en && empty) udf_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst && wr_acc) mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= bus.data_in;
   end

   generate
      if (FWFT) begin : g_fwft
         assign bus.data_out = empty ? '0 : head;
      end else begin : g_reg
         logic [DATA_WIDTH-1:0] dout_q;
         always_ff @(posedge clk) begin
            if (!rst)        dout_q <= '0;
            else if (rd_acc) dout_q <= head;
         end
         assign bus.data_out = dout_q;
      end
   endgenerate

   assign ptr_empty = (wr_ptr_q == rd_ptr_q);
   assign ptr_full  = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]) &&
                      (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);

   a_ptr_vs_count: assert property (@(posedge clk) disable iff (!rst)
      (full == ptr_full) && (empty == ptr_empty));
endmodule

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
Parametrised synchronous FIFO with an explicit occupancy counter, runtime-programmable almost-full/almost-empty thresholds, and sticky overflow/underflow error flags. A build-time mode selects a registered-output FIFO or a first-word-fall-through (FWFT) FIFO. It is the general-purpose single-clock buffer for datapath blocks that need early back-pressure and error visibility. All logic is in the clk domain.

Parameters:
DATA_WIDTH, 8, width of each stored word.
DEPTH, 16, number of entries; power of two, >= 4.
ADDR_WIDTH, 4, log2(DEPTH); set consistently by the instantiator.
FWFT, 0, 0 = registered read data (1-cycle latency); 1 = head word visible on data_out while not empty.

Ports:
clk  in  1  clock, all logic on rising edge.
rst  in  1  synchronous, active-low reset.
w_en  in  1  write request.
data_in  in  DATA_WIDTH  write data.
r_en  in  1  read (pop) request.
data_out  out  DATA_WIDTH  read data.
full  out  1  count == DEPTH.
empty  out  1  count == 0.
almost_full  out  1  count >= af_thresh.
almost_empty  out  1  count <= ae_thresh.
af_thresh  in  ADDR_WIDTH+1  almost-full threshold, sampled every cycle.
ae_thresh  in  ADDR_WIDTH+1  almost-empty threshold, sampled every cycle.
count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
overflow  out  1  sticky: write attempted while full.
underflow  out  1  sticky: read attempted while empty.
clr_err  in  1  clears overflow/underflow.

Behaviour:
- Reset (rst=0 at a clk edge): wr/rd pointers=0, count=0, data_out=0, overflow=0, underflow=0. Memory contents are not cleared. Reset overrides all other inputs in that cycle.
- Pointers: ADDR_WIDTH+1 bits; the low ADDR_WIDTH bits index memory; the MSB is a wrap bit. Both pointers increment modulo 2*DEPTH.
- Write accepted iff w_en=1 and full=0. data_in is stored at wr_ptr, and wr_ptr increments.
- Read accepted iff r_en=1 and empty=0. rd_ptr increments.
- All flags are evaluated on pre-edge state. Acceptance never depends on the same-cycle opposite operation:
  - Full with w_en and r_en both high: the read is accepted, the write is rejected, overflow is set, and count becomes DEPTH-1.
  - Empty with w_en and r_en both high: the write is accepted, the read is rejected, underflow is set, and count becomes 1.
  - Not full and not empty with both high: both are accepted and count is unchanged.
- count: +1 on write-only, -1 on read-only, unchanged otherwise. It is a register, not derived from pointers.
- full, empty, almost_full and almost_empty are combinational from count and the thresholds. With af_thresh=0, almost_full is constantly 1. af_thresh > DEPTH means almost_full never asserts.
- FWFT=0: on an accepted read, data_out <= mem[rd_ptr] at that edge, so valid data appears 1 cycle after the r_en edge. data_out holds its value when no read is accepted.
- FWFT=1: data_out = mem[rd_ptr] combinationally when empty=0, and 0 when empty=1. r_en acknowledges and pops the current word. After a write into an empty FIFO, the word is visible the cycle after the write edge (empty drops at the same edge).
- overflow/underflow: set on a rejected w_en or r_en respectively. Cleared by clr_err=1. If a set and clr_err occur in the same cycle, set wins.
- Wrap-around: full ⇔ pointer low bits equal and wrap bits differ. empty ⇔ pointers identical. Both must agree with count at all times; this is a required assertion.
- Reset mid-operation: all stored data is discarded logically. After rst returns high, the FIFO behaves as empty, with empty=1 and count=0.

Test Plan:
- Reset, then write 0x01..0x10 (16 words, DEPTH=16, FWFT=0) -> full=1 and count=16 after the 16th edge. A 17th write sets overflow=1 and count stays 16.
- From full, read 16 times -> data_out sequence 0x01..0x10, each value 1 cycle after its r_en edge. Final empty=1; an extra read sets underflow=1 and data_out holds 0x10.
- af_thresh=12, ae_thresh=3; fill one word at a time -> almost_empty=1 for count 0..3, almost_full=1 from count=12. Change af_thresh to 14 at count 12 -> almost_full drops the same cycle.
- Steady state at count=8, w_en=r_en=1 for 40 cycles with an incrementing pattern -> count stays 8, data is read in order across multiple pointer wraps, and no error flags set.
- Simultaneous w_en=r_en=1 at full -> count=15, overflow=1, underflow=0. Then clr_err=1 with w_en=0 -> overflow=0 next cycle.
- FWFT=1: write 0xA5 into an empty FIFO -> data_out=0xA5 and empty=0 the next cycle with no r_en. One r_en -> empty=1 and data_out=0. Assert rst mid-fill at count=5 -> count=0 and empty=1 after the edge.
